// File: rtl/maxpool_2x2_sequencer_pkg.sv
// Shared state encoding and window geometry for the 2x2 max-pool sequencer.
// Pure declarations: no latency, no flow control.
package maxpool_2x2_sequencer_pkg;

  localparam int POOL_STRIDE = 2;

  typedef enum logic [1:0] {
    ROW_TOP   = 2'd0,
    ROW_BOT   = 2'd1,
    DRAIN_ROW = 2'd2
  } pool_state_e;

endpackage

// File: rtl/maxpool_2x2_sequencer_if.sv
// Pixel-in / window-out bundle between the conv stream, the sequencer and the max unit.
// Plain valid strobes both ways; the pixel side has no backpressure.
interface maxpool_2x2_sequencer_if
  import maxpool_2x2_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] o_data_0;
  logic [DATA_WIDTH-1:0] o_data_1;
  logic [DATA_WIDTH-1:0] o_data_2;
  logic [DATA_WIDTH-1:0] o_data_3;
  logic                  o_valid;
  logic                  o_last;
  logic                  o_frame_done;

  modport master (
    output i_data, i_valid,
    input  o_data_0, o_data_1, o_data_2, o_data_3, o_valid, o_last, o_frame_done
  );

  modport slave (
    input  i_data, i_valid,
    output o_data_0, o_data_1, o_data_2, o_data_3, o_valid, o_last, o_frame_done
  );

endinterface

// File: rtl/maxpool_2x2_sequencer_pool_line_buffer.sv
// One-row pixel store: synchronous write, two combinational read ports (registered by the parent).
// Latency 0 on reads; never stalls.
module pool_line_buffer
  import maxpool_2x2_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 224,
  parameter int ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  rd_addr_0,
  input  logic [ADDR_BITS-1:0]  rd_addr_1,
  output logic [DATA_WIDTH-1:0] rd_data_0,
  output logic [DATA_WIDTH-1:0] rd_data_1
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_0 = mem[rd_addr_0];
  assign rd_data_1 = mem[rd_addr_1];

endmodule

// File: rtl/maxpool_2x2_sequencer.sv
// Groups a row-major pixel stream into 2x2 windows for a 4-input max unit; flags last window / frame end.
// Window operands registered 1 cycle after the bottom-right pixel; input is never backpressured.
module maxpool_2x2_sequencer
  import maxpool_2x2_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224,
  parameter int COL_BITS   = $clog2(IMG_WIDTH),
  parameter int ROW_BITS   = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  maxpool_2x2_sequencer_if.slave bus
);

  localparam int WIN_COL_LAST = POOL_STRIDE * (IMG_WIDTH / POOL_STRIDE) - 1;
  localparam int WIN_ROW_LAST = POOL_STRIDE * (IMG_HEIGHT / POOL_STRIDE) - 1;
  localparam bit ODD_HEIGHT   = (IMG_HEIGHT % POOL_STRIDE) != 0;

  pool_state_e state, state_nxt;

  logic [COL_BITS-1:0]   col;
  logic [ROW_BITS-1:0]   row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] top_left, top_right;
  logic                  col_wrap, row_wrap, last_win;
  logic                  buf_we, hold_en, win_issue;

  logic [DATA_WIDTH-1:0] data_0, data_1, data_2, data_3;
  logic                  valid, last, frame_done;

  assign col_wrap = (col == COL_BITS'(IMG_WIDTH - 1));
  assign row_wrap = (row == ROW_BITS'(IMG_HEIGHT - 1));
  assign last_win = (col == COL_BITS'(WIN_COL_LAST)) && (row == ROW_BITS'(WIN_ROW_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ROW_TOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Odd columns of a bottom row close a window; even columns park the bottom-left pixel.
  always_comb begin
    state_nxt = state;
    buf_we    = 1'b0;
    hold_en   = 1'b0;
    win_issue = 1'b0;
    case (state)
      ROW_TOP: begin
        buf_we = bus.i_valid;
        if (bus.i_valid && col_wrap) begin
          state_nxt = ROW_BOT;
        end
      end
      ROW_BOT: begin
        hold_en   = bus.i_valid && !col[0];
        win_issue = bus.i_valid && col[0];
        if (bus.i_valid && col_wrap) begin
          if (ODD_HEIGHT && (row == ROW_BITS'(IMG_HEIGHT - 2))) begin
            state_nxt = DRAIN_ROW;
          end else begin
            state_nxt = ROW_TOP;
          end
        end
      end
      DRAIN_ROW: begin
        if (bus.i_valid && col_wrap) begin
          state_nxt = ROW_TOP;
        end
      end
      default: state_nxt = ROW_TOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.i_valid) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + ROW_BITS'(1);
      end else begin
        col <= col + COL_BITS'(1);
      end
    end
  end

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_BITS  (COL_BITS)
  ) u_line_buffer (
    .clk       (clk),
    .we        (buf_we),
    .wr_addr   (col),
    .wr_data   (bus.i_data),
    .rd_addr_0 (col - COL_BITS'(1)),
    .rd_addr_1 (col),
    .rd_data_0 (top_left),
    .rd_data_1 (top_right)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      data_0     <= '0;
      data_1     <= '0;
      data_2     <= '0;
      data_3     <= '0;
      valid      <= 1'b0;
      last       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid      <= win_issue;
      last       <= win_issue && last_win;
      frame_done <= bus.i_valid && col_wrap && row_wrap;
      if (hold_en) begin
        hold <= bus.i_data;
      end
      if (win_issue) begin
        data_0 <= top_left;
        data_1 <= top_right;
        data_2 <= hold;
        data_3 <= bus.i_data;
      end
    end
  end

  assign bus.o_data_0     = data_0;
  assign bus.o_data_1     = data_1;
  assign bus.o_data_2     = data_2;
  assign bus.o_data_3     = data_3;
  assign bus.o_valid      = valid;
  assign bus.o_last       = last;
  assign bus.o_frame_done = frame_done;

endmodule

// File: tb/tb_maxpool_2x2_sequencer.sv
// Scoreboard bench: 4x4 and 5x5 sequencers driven with directed frames; a monitor pops expected windows.
module tb_maxpool_2x2_sequencer;
  import maxpool_2x2_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxpool_2x2_sequencer_if #(.DATA_WIDTH(32)) if4 ();
  maxpool_2x2_sequencer_if #(.DATA_WIDTH(32)) if5 ();

  maxpool_2x2_sequencer #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4)
  );
  maxpool_2x2_sequencer #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
    .clk(clk), .rst(rst), .bus(if5)
  );

  typedef struct {
    logic [31:0] d0, d1, d2, d3;
    logic        last;
    int          cyc;
  } win_t;

  win_t q4[$];
  win_t q5[$];
  int   fd4[$];
  int   fd5[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_idle = 0;
  bit end_req  = 0;
  bit end_done = 0;

  // Hand-computed windows (pixel offsets within a frame) and the pixel that closes each one.
  int win4 [4][4] = '{'{0, 1, 4, 5}, '{2, 3, 6, 7}, '{8, 9, 12, 13}, '{10, 11, 14, 15}};
  int br4  [4]    = '{5, 7, 13, 15};
  int win5 [4][4] = '{'{0, 1, 5, 6}, '{2, 3, 7, 8}, '{10, 11, 15, 16}, '{12, 13, 17, 18}};
  int br5  [4]    = '{6, 8, 16, 18};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic send_frame(input bit sel5, input int base, input int npix, input bit gaps);
    win_t e;
    int   total;
    total = sel5 ? 25 : 16;
    for (int p = 0; p < npix; p++) begin
      @(negedge clk);
      if (sel5) begin
        if5.i_data  = 32'(base + p);
        if5.i_valid = 1'b1;
      end else begin
        if4.i_data  = 32'(base + p);
        if4.i_valid = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        if (sel5 ? (br5[k] == p) : (br4[k] == p)) begin
          e.d0   = 32'(base + (sel5 ? win5[k][0] : win4[k][0]));
          e.d1   = 32'(base + (sel5 ? win5[k][1] : win4[k][1]));
          e.d2   = 32'(base + (sel5 ? win5[k][2] : win4[k][2]));
          e.d3   = 32'(base + (sel5 ? win5[k][3] : win4[k][3]));
          e.last = (k == 3);
          e.cyc  = cyc + 1;
          if (sel5) q5.push_back(e);
          else      q4.push_back(e);
        end
      end
      if (p == total - 1) begin
        if (sel5) fd5.push_back(cyc + 1);
        else      fd4.push_back(cyc + 1);
      end
      if (gaps) begin
        @(negedge clk);
        if4.i_valid = 1'b0;
        if5.i_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if4.i_valid = 1'b0;
      if5.i_valid = 1'b0;
    end
  endtask

  task automatic check_win(input string nm, input bit have, input win_t e,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input logic last);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s unexpected window got=(%0d,%0d,%0d,%0d) last=%0b at cyc=%0d",
               nm, d0, d1, d2, d3, last, cyc);
    end else if (d0 !== e.d0 || d1 !== e.d1 || d2 !== e.d2 || d3 !== e.d3 ||
                 last !== e.last || cyc != e.cyc) begin
      failures++;
      $display("FAIL %s got=(%0d,%0d,%0d,%0d) last=%0b cyc=%0d expected=(%0d,%0d,%0d,%0d) last=%0b cyc=%0d",
               nm, d0, d1, d2, d3, last, cyc, e.d0, e.d1, e.d2, e.d3, e.last, e.cyc);
    end
  endtask

  task automatic check_fd(input string nm, input bit have, input int exp_cyc);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s unexpected frame_done at cyc=%0d", nm, cyc);
    end else if (cyc != exp_cyc) begin
      failures++;
      $display("FAIL %s frame_done at cyc=%0d expected cyc=%0d", nm, cyc, exp_cyc);
    end
  endtask

  // Single checking process: owns the counters, stimulus only pushes expectations.
  always @(negedge clk) begin
    win_t e;
    int   c;
    bit   have;
    if (chk_idle) begin
      checks++;
      if ({if4.o_valid, if4.o_last, if4.o_frame_done, if5.o_valid, if5.o_last, if5.o_frame_done} != 6'b0 ||
          (if4.o_data_0 | if4.o_data_1 | if4.o_data_2 | if4.o_data_3) != 32'd0 ||
          (if5.o_data_0 | if5.o_data_1 | if5.o_data_2 | if5.o_data_3) != 32'd0) begin
        failures++;
        $display("FAIL idle_zero got v4=%0b l4=%0b f4=%0b v5=%0b l5=%0b f5=%0b d4=(%0d,%0d,%0d,%0d) required all 0",
                 if4.o_valid, if4.o_last, if4.o_frame_done, if5.o_valid, if5.o_last, if5.o_frame_done,
                 if4.o_data_0, if4.o_data_1, if4.o_data_2, if4.o_data_3);
      end
    end
    if (if4.o_valid) begin
      have = (q4.size() != 0);
      if (have) e = q4.pop_front();
      check_win("win4", have, e, if4.o_data_0, if4.o_data_1, if4.o_data_2, if4.o_data_3, if4.o_last);
    end else if (if4.o_last) begin
      checks++;
      failures++;
      $display("FAIL last4_without_valid got o_last=1 o_valid=0 required o_last=0");
    end
    if (if5.o_valid) begin
      have = (q5.size() != 0);
      if (have) e = q5.pop_front();
      check_win("win5", have, e, if5.o_data_0, if5.o_data_1, if5.o_data_2, if5.o_data_3, if5.o_last);
    end else if (if5.o_last) begin
      checks++;
      failures++;
      $display("FAIL last5_without_valid got o_last=1 o_valid=0 required o_last=0");
    end
    if (if4.o_frame_done) begin
      have = (fd4.size() != 0);
      c = have ? fd4.pop_front() : 0;
      check_fd("fd4", have, c);
    end
    if (if5.o_frame_done) begin
      have = (fd5.size() != 0);
      c = have ? fd5.pop_front() : 0;
      check_fd("fd5", have, c);
    end
    if (end_req && !end_done) begin
      checks += 4;
      if (q4.size() != 0)  begin failures++; $display("FAIL win4_missing got %0d pending required 0", q4.size()); end
      if (q5.size() != 0)  begin failures++; $display("FAIL win5_missing got %0d pending required 0", q5.size()); end
      if (fd4.size() != 0) begin failures++; $display("FAIL fd4_missing got %0d pending required 0", fd4.size()); end
      if (fd5.size() != 0) begin failures++; $display("FAIL fd5_missing got %0d pending required 0", fd5.size()); end
      end_done = 1'b1;
    end
  end

  initial begin
    if4.i_valid = 1'b0;
    if4.i_data  = '0;
    if5.i_valid = 1'b0;
    if5.i_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and quiet bus.
    chk_idle = 1'b1;
    idle(20);
    chk_idle = 1'b0;

    // 4x4 back-to-back, then with 1-0-1-0 valid.
    send_frame(1'b0, 0, 16, 1'b0);
    idle(3);
    send_frame(1'b0, 0, 16, 1'b1);
    idle(3);

    // 5x5: odd width and height, floor pooling.
    send_frame(1'b1, 0, 25, 1'b0);
    idle(3);

    // Two frames with no gap; distinct data per frame.
    send_frame(1'b0, 100, 16, 1'b0);
    send_frame(1'b0, 300, 16, 1'b0);
    idle(3);

    // Abort after pixel 6, then a clean frame.
    send_frame(1'b0, 200, 7, 1'b0);
    @(negedge clk);
    if4.i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_frame(1'b0, 0, 16, 1'b0);
    idle(5);

    end_req = 1'b1;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
